// File: rtl/peripheral_stream_csr_agent.sv
// Avalon-MM pipelined slave that buffers an RX packet stream in a small FIFO
// and exposes it, together with status/control/scratch registers, through a
// 16-word register window. Read data returns with a fixed two-cycle latency.
module peripheral_stream_csr_agent #(
  parameter int DEPTH   = 16,
  parameter int FILL_W  = 5,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [5:0]  address,
  input  logic [3:0]  byteenable,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic        waitrequest,
  output logic [31:0] readdata,
  output logic        readdatavalid,
  output logic        endofpacket,
  input  logic        snk_valid,
  input  logic [31:0] snk_data,
  input  logic        snk_endofpacket,
  output logic        snk_ready,
  output logic        irq
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic {ST_IDLE, ST_WAIT} state_e;

  typedef enum logic [3:0] {
    REG_DATA     = 4'd0,
    REG_STATUS   = 4'd1,
    REG_CONTROL  = 4'd2,
    REG_PKTCOUNT = 4'd3,
    REG_SCRATCH  = 4'd4
  } reg_e;

  typedef struct packed {
    logic        eop;
    logic [31:0] data;
  } word_t;

  word_t             mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FILL_W-1:0] fill_q, fill_d, pkt_q, pkt_d;
  state_e            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              underflow_q, underflow_d;
  logic              irq_en_q, irq_en_d;
  logic              irq_q, irq_d;
  logic [31:0]       scratch_q, scratch_d;
  logic              snk_ready_q, snk_ready_d;
  logic              s1_valid_q, s1_valid_d, s1_eop_q, s1_eop_d;
  logic [31:0]       s1_data_q, s1_data_d;
  logic              rdv_q, rdv_d, eop_q, eop_d;
  logic [31:0]       rdata_q, rdata_d;

  logic [3:0]  idx;
  logic        empty, data_rd, stall, rd_acc, wr_acc, pop, push, flush;
  word_t       head;
  logic [31:0] rd_word;
  logic        rd_eop;
  logic        addr_unused;

  assign idx         = address[5:2];
  assign addr_unused = ^address[1:0];
  assign empty       = (fill_q == '0);
  assign head        = mem_q[rd_ptr_q];
  assign data_rd     = read && (idx == REG_DATA);

  // Stall decision for DATA reads on an empty buffer, with bounded wait.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (data_rd && empty) begin
          stall   = 1'b1;
          state_d = ST_WAIT;
          cnt_d   = 16'd1;
        end
      end
      ST_WAIT: begin
        if (!data_rd || !empty || cnt_q == 16'(TIMEOUT)) begin
          state_d = ST_IDLE;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign waitrequest = stall;
  assign rd_acc      = read && !stall;
  assign wr_acc      = write && !read;
  assign pop         = rd_acc && (idx == REG_DATA) && !empty;
  assign flush       = wr_acc && (idx == REG_CONTROL) && byteenable[0] && writedata[1];
  assign push        = snk_valid && snk_ready_q && !flush;

  // Register readback, sampled at the accept cycle.
  always_comb begin
    rd_word = '0;
    rd_eop  = 1'b0;
    case (idx)
      REG_DATA: begin
        if (!empty) begin
          rd_word = head.data;
          rd_eop  = head.eop;
        end
      end
      REG_STATUS: begin
        rd_word[FILL_W-1:0] = fill_q;
        rd_word[8]          = underflow_q;
        rd_word[9]          = irq_q;
      end
      REG_CONTROL:  rd_word[0]          = irq_en_q;
      REG_PKTCOUNT: rd_word[FILL_W-1:0] = pkt_q;
      REG_SCRATCH:  rd_word             = scratch_q;
      default: ;
    endcase
  end

  // Buffer bookkeeping, register writes and the two-stage read pipeline.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    underflow_d = underflow_q;
    irq_en_d    = irq_en_q;
    scratch_d   = scratch_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    fill_d = fill_q + FILL_W'(push) - FILL_W'(pop);
    pkt_d  = pkt_q + FILL_W'(push && snk_endofpacket) - FILL_W'(pop && head.eop);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      fill_d   = '0;
      pkt_d    = '0;
    end
    if (rd_acc && idx == REG_DATA && empty) underflow_d = 1'b1;
    if (wr_acc) begin
      case (idx)
        REG_STATUS:  if (byteenable[1] && writedata[8]) underflow_d = 1'b0;
        REG_CONTROL: if (byteenable[0]) irq_en_d = writedata[0];
        REG_SCRATCH: begin
          for (int b = 0; b < 4; b++) begin
            if (byteenable[b]) scratch_d[8*b +: 8] = writedata[8*b +: 8];
          end
        end
        default: ;
      endcase
    end
    snk_ready_d = (fill_d < FILL_W'(DEPTH));
    irq_d       = irq_en_q && (pkt_q != '0);
    s1_valid_d  = rd_acc;
    s1_data_d   = rd_word;
    s1_eop_d    = rd_eop;
    rdv_d       = s1_valid_q;
    rdata_d     = s1_valid_q ? s1_data_q : 32'h0;
    eop_d       = s1_valid_q && s1_eop_q;
  end

  // Stream storage written on push.
  // NOTE: the storage array has no reset; the pointers and fill level define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{eop: snk_endofpacket, data: snk_data};
  end

  // State, control registers and response pipeline.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fill_q      <= '0;
      pkt_q       <= '0;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      underflow_q <= 1'b0;
      irq_en_q    <= 1'b0;
      irq_q       <= 1'b0;
      scratch_q   <= '0;
      snk_ready_q <= 1'b1;
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_eop_q    <= 1'b0;
      rdv_q       <= 1'b0;
      rdata_q     <= '0;
      eop_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fill_q      <= fill_d;
      pkt_q       <= pkt_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      underflow_q <= underflow_d;
      irq_en_q    <= irq_en_d;
      irq_q       <= irq_d;
      scratch_q   <= scratch_d;
      snk_ready_q <= snk_ready_d;
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_eop_q    <= s1_eop_d;
      rdv_q       <= rdv_d;
      rdata_q     <= rdata_d;
      eop_q       <= eop_d;
    end
  end

  assign readdata      = rdata_q;
  assign readdatavalid = rdv_q;
  assign endofpacket   = eop_q;
  assign snk_ready     = snk_ready_q;
  assign irq           = irq_q;

endmodule

// File: tb/tb_peripheral_stream_csr_agent.sv
// Directed bench for peripheral_stream_csr_agent: a register-access vector
// table plus hand-written sequences for stream, stall, timeout, irq and reset.
module tb_peripheral_stream_csr_agent;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [5:0]  address = '0;
  logic [3:0]  byteenable = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        readdatavalid;
  logic        endofpacket;
  logic        snk_valid = 1'b0;
  logic [31:0] snk_data = '0;
  logic        snk_endofpacket = 1'b0;
  logic        snk_ready;
  logic        irq;

  int checks = 0;
  int errors = 0;

  logic [31:0] rd_d;
  logic        rd_e;
  int          stall;

  typedef struct packed {
    logic        wr;
    logic [3:0]  idx;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] exp_data;
    logic        exp_eop;
  } vec_t;

  vec_t vecs [10];

  peripheral_stream_csr_agent #(.DEPTH(16), .FILL_W(5), .TIMEOUT(255)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
    .read(read), .write(write), .writedata(writedata), .waitrequest(waitrequest),
    .readdata(readdata), .readdatavalid(readdatavalid), .endofpacket(endofpacket),
    .snk_valid(snk_valid), .snk_data(snk_data), .snk_endofpacket(snk_endofpacket),
    .snk_ready(snk_ready), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [3:0] idx, input logic [3:0] be, input logic [31:0] wd);
    address = {idx, 2'b00};
    byteenable = be;
    writedata = wd;
    write = 1'b1;
    @(posedge clk);
    #1;
    write = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] idx, output logic [31:0] d, output logic e,
                         output int st);
    address = {idx, 2'b00};
    byteenable = 4'hF;
    read = 1'b1;
    st = 0;
    #1;
    while (waitrequest === 1'b1 && st < 1000) begin
      st++;
      @(posedge clk);
      #1;
    end
    if (st >= 1000) check("stall_bound", 32'(st), 32'd0);
    @(posedge clk);
    #1;
    read = 1'b0;
    check("rdv_at_t1", {31'b0, readdatavalid}, 32'd0);
    @(posedge clk);
    #1;
    check("rdv_at_t2", {31'b0, readdatavalid}, 32'd1);
    d = readdata;
    e = endofpacket;
  endtask

  task automatic push(input logic [31:0] d, input logic eop);
    snk_data = d;
    snk_endofpacket = eop;
    snk_valid = 1'b1;
    @(posedge clk);
    #1;
    snk_valid = 1'b0;
    snk_endofpacket = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [3:0] idx,
                            input logic [31:0] exp, input logic exp_eop);
    logic [31:0] d;
    logic        e;
    int          s;
    do_read(idx, d, e, s);
    check(name, d, exp);
    check({name, "_eop"}, {31'b0, e}, {31'b0, exp_eop});
  endtask

  initial begin
    vecs[0] = '{1'b1, 4'd4, 4'b0101, 32'hDEADBEEF, 32'h0,        1'b0};
    vecs[1] = '{1'b0, 4'd4, 4'b1111, 32'h0,        32'h00AD00EF, 1'b0};
    vecs[2] = '{1'b1, 4'd4, 4'b1010, 32'h12345678, 32'h0,        1'b0};
    vecs[3] = '{1'b0, 4'd4, 4'b1111, 32'h0,        32'h12AD56EF, 1'b0};
    vecs[4] = '{1'b1, 4'd7, 4'b1111, 32'hFFFFFFFF, 32'h0,        1'b0};
    vecs[5] = '{1'b0, 4'd7, 4'b1111, 32'h0,        32'h0,        1'b0};
    vecs[6] = '{1'b0, 4'd15, 4'b1111, 32'h0,       32'h0,        1'b0};
    vecs[7] = '{1'b1, 4'd2, 4'b0001, 32'h00000001, 32'h0,        1'b0};
    vecs[8] = '{1'b0, 4'd2, 4'b1111, 32'h0,        32'h00000001, 1'b0};
    vecs[9] = '{1'b1, 4'd2, 4'b0001, 32'h00000000, 32'h0,        1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    cycle();
    check("reset_rdv", {31'b0, readdatavalid}, 32'd0);
    check("reset_rdata", readdata, 32'h0);
    check("reset_snk_ready", {31'b0, snk_ready}, 32'd1);
    check("reset_irq", {31'b0, irq}, 32'd0);
    check("reset_wait", {31'b0, waitrequest}, 32'd0);
    read_check("reset_status", 4'd1, 32'h0, 1'b0);

    // Register-window vectors
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].wr) begin
        do_write(vecs[i].idx, vecs[i].be, vecs[i].wd);
      end else begin
        read_check($sformatf("vec%0d", i), vecs[i].idx, vecs[i].exp_data, vecs[i].exp_eop);
      end
    end

    // Read and write together: read serviced, write dropped
    address = {4'd4, 2'b00};
    byteenable = 4'hF;
    writedata = 32'h0;
    read = 1'b1;
    write = 1'b1;
    cycle();
    read = 1'b0;
    write = 1'b0;
    cycle();
    check("rw_rdv", {31'b0, readdatavalid}, 32'd1);
    check("rw_data", readdata, 32'h12AD56EF);
    read_check("rw_scratch_kept", 4'd4, 32'h12AD56EF, 1'b0);

    // Back-to-back DATA reads
    push(32'hA1, 1'b0);
    push(32'hA2, 1'b0);
    push(32'hA3, 1'b1);
    address = 6'h0;
    read = 1'b1;
    #1;
    check("b2b_wait", {31'b0, waitrequest}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (i == 2) read = 1'b0;
      check($sformatf("b2b_rdv%0d", i), {31'b0, readdatavalid}, (i >= 1 && i <= 3) ? 32'd1 : 32'd0);
      if (i >= 1 && i <= 3) begin
        check($sformatf("b2b_data%0d", i), readdata, 32'hA0 + 32'(i));
        check($sformatf("b2b_eop%0d", i), {31'b0, endofpacket}, (i == 3) ? 32'd1 : 32'd0);
      end
    end
    read_check("b2b_pktcount", 4'd3, 32'h0, 1'b0);
    read_check("b2b_status", 4'd1, 32'h0, 1'b0);

    // Fill to DEPTH, reject push when full
    snk_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      snk_data = 32'h100 + 32'(i);
      cycle();
    end
    snk_valid = 1'b0;
    check("full_snk_ready", {31'b0, snk_ready}, 32'd0);
    push(32'hBAD, 1'b1);
    read_check("full_status", 4'd1, 32'h10, 1'b0);
    read_check("full_pktcount", 4'd3, 32'h0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      read_check($sformatf("pop%0d", i), 4'd0, 32'h100 + 32'(i), 1'b0);
    end
    check("half_snk_ready", {31'b0, snk_ready}, 32'd1);

    // Push (EOP) and pop (non-EOP) in the same cycle
    address = 6'h0;
    read = 1'b1;
    snk_data = 32'h1EE;
    snk_endofpacket = 1'b1;
    snk_valid = 1'b1;
    #1;
    check("pp_wait", {31'b0, waitrequest}, 32'd0);
    cycle();
    read = 1'b0;
    snk_valid = 1'b0;
    snk_endofpacket = 1'b0;
    cycle();
    check("pp_rdv", {31'b0, readdatavalid}, 32'd1);
    check("pp_data", readdata, 32'h108);
    read_check("pp_status", 4'd1, 32'h8, 1'b0);
    read_check("pp_pktcount", 4'd3, 32'h1, 1'b0);

    // Flush with a concurrent push: push discarded
    snk_data = 32'hCC;
    snk_valid = 1'b1;
    do_write(4'd2, 4'b0001, 32'h2);
    snk_valid = 1'b0;
    read_check("flush_status", 4'd1, 32'h0, 1'b0);
    read_check("flush_pktcount", 4'd3, 32'h0, 1'b0);
    read_check("flush_control", 4'd2, 32'h0, 1'b0);

    // Stall on empty, word arrives later
    fork
      do_read(4'd0, rd_d, rd_e, stall);
      begin
        repeat (10) cycle();
        push(32'h55, 1'b0);
      end
    join
    check("late_stall", 32'(stall), 32'd11);
    check("late_data", rd_d, 32'h55);
    check("late_eop", {31'b0, rd_e}, 32'd0);
    read_check("late_status", 4'd1, 32'h0, 1'b0);

    // Timeout on empty
    do_read(4'd0, rd_d, rd_e, stall);
    check("to_stall", 32'(stall), 32'd255);
    check("to_data", rd_d, 32'h0);
    check("to_eop", {31'b0, rd_e}, 32'd0);
    read_check("to_status", 4'd1, 32'h100, 1'b0);
    do_write(4'd1, 4'b0001, 32'h100);
    read_check("to_clr_wrong_lane", 4'd1, 32'h100, 1'b0);
    do_write(4'd1, 4'b0010, 32'h100);
    read_check("to_clr", 4'd1, 32'h0, 1'b0);

    // Word pushed on the timeout cycle stays buffered
    fork
      do_read(4'd0, rd_d, rd_e, stall);
      begin
        repeat (255) cycle();
        push(32'h99, 1'b0);
      end
    join
    check("to2_stall", 32'(stall), 32'd255);
    check("to2_data", rd_d, 32'h0);
    read_check("to2_status", 4'd1, 32'h101, 1'b0);
    read_check("to2_pop", 4'd0, 32'h99, 1'b0);
    do_write(4'd1, 4'b0010, 32'h100);

    // irq timing and flush
    do_write(4'd2, 4'b0001, 32'h1);
    push(32'h77, 1'b1);
    check("irq_lag", {31'b0, irq}, 32'd0);
    cycle();
    check("irq_set", {31'b0, irq}, 32'd1);
    read_check("irq_status", 4'd1, 32'h201, 1'b0);
    do_write(4'd2, 4'b0001, 32'h3);
    cycle();
    check("irq_clr", {31'b0, irq}, 32'd0);
    read_check("irq_fill", 4'd1, 32'h0, 1'b0);
    read_check("irq_ctrl", 4'd2, 32'h1, 1'b0);

    // Reset mid-operation drops in-flight response
    push(32'h42, 1'b1);
    cycle();
    check("pre_rst_irq", {31'b0, irq}, 32'd1);
    address = 6'h0;
    read = 1'b1;
    cycle();
    read = 1'b0;
    reset_n = 1'b0;
    #1;
    check("rst_rdv", {31'b0, readdatavalid}, 32'd0);
    check("rst_irq", {31'b0, irq}, 32'd0);
    check("rst_snk_ready", {31'b0, snk_ready}, 32'd1);
    cycle();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check($sformatf("rst_no_rdv%0d", i), {31'b0, readdatavalid}, 32'd0);
    end
    read_check("rst_status", 4'd1, 32'h0, 1'b0);
    read_check("rst_ctrl", 4'd2, 32'h0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
